// File: rtl/nettlp_cmd_pkg.sv
// Shared types and constants for the NetTLP command processor.
// Opcodes, adapter register addresses, FIFO/response entry layouts, FSM states
// and the register-file readback helper used by nettlp_adapter_regs.
package nettlp_cmd_pkg;

    localparam logic [31:0] NETTLP_MAGIC_VALUE      = 32'h4E54_4C50;
    localparam logic [31:0] NETTLP_CMD_RESP_INVALID = 32'hFFFF_FFFF;

    // Command opcodes carried in UDP port 0x5002 packets
    localparam logic [7:0] NETTLP_CMD_REG_RD  = 8'h10;
    localparam logic [7:0] NETTLP_CMD_REG_WR  = 8'h11;
    localparam logic [7:0] NETTLP_CMD_MAGIC   = 8'h20;
    localparam logic [7:0] NETTLP_CMD_TSTAMP  = 8'h21;
    localparam logic [7:0] NETTLP_CMD_RST_ALL = 8'h22;

    // Adapter register map (dword addresses)
    localparam logic [7:0] ADAPTER_REG_MAGIC        = 8'h00;
    localparam logic [7:0] ADAPTER_REG_DSTMAC_LOW   = 8'h01;
    localparam logic [7:0] ADAPTER_REG_DSTMAC_HIGH  = 8'h02;
    localparam logic [7:0] ADAPTER_REG_SRCMAC_LOW   = 8'h03;
    localparam logic [7:0] ADAPTER_REG_SRCMAC_HIGH  = 8'h04;
    localparam logic [7:0] ADAPTER_REG_DSTIP        = 8'h05;
    localparam logic [7:0] ADAPTER_REG_SRCIP        = 8'h06;
    localparam logic [7:0] ADAPTER_REG_DSTPORT      = 8'h07;
    localparam logic [7:0] ADAPTER_REG_SRCPORT      = 8'h08;
    localparam logic [7:0] ADAPTER_REG_REQUESTER_ID = 8'h09;
    localparam logic [7:0] ADAPTER_REG_ERRCNT       = 8'h20;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  dwaddr;
        logic [31:0] data;
    } NETTLP_CMD_T;

    typedef struct packed {
        logic        data_valid;
        NETTLP_CMD_T cmd;
    } FIFO_NETTLP_CMD_T;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        SRST = 2'd2,
        RESP = 2'd3
    } CMD_PROC_STATE_T;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] dst_ip;
        logic [31:0] src_ip;
        logic [15:0] dst_port;
        logic [15:0] src_port;
        logic [15:0] requester_id;
    } ADAPTER_REGS_T;

    // True for addresses backed by the register file (magic included)
    function automatic logic adapter_reg_mapped(input logic [7:0] addr);
        return (addr <= ADAPTER_REG_REQUESTER_ID);
    endfunction

    // Dword view of the register file; unmapped addresses read as zero
    function automatic logic [31:0] adapter_reg_read(input ADAPTER_REGS_T regs,
                                                     input logic [7:0]    addr,
                                                     input logic [31:0]   magic);
        logic [31:0] data;
        data = '0;
        case (addr)
            ADAPTER_REG_MAGIC:        data = magic;
            ADAPTER_REG_DSTMAC_LOW:   data = regs.dst_mac[31:0];
            ADAPTER_REG_DSTMAC_HIGH:  data = {16'h0, regs.dst_mac[47:32]};
            ADAPTER_REG_SRCMAC_LOW:   data = regs.src_mac[31:0];
            ADAPTER_REG_SRCMAC_HIGH:  data = {16'h0, regs.src_mac[47:32]};
            ADAPTER_REG_DSTIP:        data = regs.dst_ip;
            ADAPTER_REG_SRCIP:        data = regs.src_ip;
            ADAPTER_REG_DSTPORT:      data = {16'h0, regs.dst_port};
            ADAPTER_REG_SRCPORT:      data = {16'h0, regs.src_port};
            ADAPTER_REG_REQUESTER_ID: data = {16'h0, regs.requester_id};
            default:                  data = '0;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/nettlp_adapter_regs.sv
// Adapter register file: MACs, IPs, UDP ports and requester ID.
// Supports a single-field write, a bulk load of defaults, and a readback of the
// value the addressed register will hold after this cycle's update.
module nettlp_adapter_regs
    import nettlp_cmd_pkg::*;
#(
    parameter logic [31:0]   MAGIC_VALUE  = NETTLP_MAGIC_VALUE,
    parameter ADAPTER_REGS_T REGS_DEFAULT = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_defaults_i,
    input  logic          wr_en_i,
    input  logic [7:0]    addr_i,
    input  logic [31:0]   wr_data_i,
    output logic [31:0]   rd_data_o,
    output ADAPTER_REGS_T regs_o
);

    ADAPTER_REGS_T regs_q, regs_d;

    // Next-state: defaults load wins over a write; magic/unmapped writes are dropped
    always_comb begin
        regs_d = regs_q;
        if (load_defaults_i) begin
            regs_d = REGS_DEFAULT;
        end else if (wr_en_i) begin
            case (addr_i)
                ADAPTER_REG_DSTMAC_LOW:   regs_d.dst_mac[31:0]  = wr_data_i;
                ADAPTER_REG_DSTMAC_HIGH:  regs_d.dst_mac[47:32] = wr_data_i[15:0];
                ADAPTER_REG_SRCMAC_LOW:   regs_d.src_mac[31:0]  = wr_data_i;
                ADAPTER_REG_SRCMAC_HIGH:  regs_d.src_mac[47:32] = wr_data_i[15:0];
                ADAPTER_REG_DSTIP:        regs_d.dst_ip         = wr_data_i;
                ADAPTER_REG_SRCIP:        regs_d.src_ip         = wr_data_i;
                ADAPTER_REG_DSTPORT:      regs_d.dst_port       = wr_data_i[15:0];
                ADAPTER_REG_SRCPORT:      regs_d.src_port       = wr_data_i[15:0];
                ADAPTER_REG_REQUESTER_ID: regs_d.requester_id   = wr_data_i[15:0];
                default: ;
            endcase
        end
    end

    // Register file state, defaults on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= REGS_DEFAULT;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Readback of the post-update value so a write response echoes what was stored
    assign rd_data_o = adapter_reg_read(regs_d, addr_i, MAGIC_VALUE);
    assign regs_o    = regs_q;

endmodule

// File: rtl/nettlp_cmd_proc.sv
// NetTLP command executor: pops one command at a time from the command FIFO,
// executes it against the adapter register file and returns one response.
// Optional build macro: NETTLP_CMD_ERRCNT_EN adds a saturating error counter
// readable at dword address 0x20 (write clears it).
module nettlp_cmd_proc
    import nettlp_cmd_pkg::*;
#(
    parameter logic [31:0] MAGIC_VALUE = NETTLP_MAGIC_VALUE,
    parameter logic [47:0] DEF_DSTMAC  = 48'h0,
    parameter logic [47:0] DEF_SRCMAC  = 48'h0,
    parameter logic [31:0] DEF_DSTIP   = 32'h0,
    parameter logic [31:0] DEF_SRCIP   = 32'h0,
    parameter logic [15:0] DEF_DSTPORT = 16'h3000,
    parameter logic [15:0] DEF_SRCPORT = 16'h3000,
    parameter logic [15:0] DEF_REQ_ID  = 16'h0,
    parameter int          RST_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  FIFO_NETTLP_CMD_T fifo_dout,
    output logic             resp_valid,
    input  logic             resp_ready,
    output NETTLP_CMD_T      resp_data,
    output logic             soft_rst,
    output logic [47:0]      dst_mac,
    output logic [47:0]      src_mac,
    output logic [31:0]      dst_ip,
    output logic [31:0]      src_ip,
    output logic [15:0]      dst_port,
    output logic [15:0]      src_port,
    output logic [15:0]      requester_id
);

    localparam ADAPTER_REGS_T REGS_DEFAULT = '{
        dst_mac:      DEF_DSTMAC,
        src_mac:      DEF_SRCMAC,
        dst_ip:       DEF_DSTIP,
        src_ip:       DEF_SRCIP,
        dst_port:     DEF_DSTPORT,
        src_port:     DEF_SRCPORT,
        requester_id: DEF_REQ_ID
    };
    localparam logic [7:0] SRST_LAST = 8'(RST_CYCLES - 1);

    CMD_PROC_STATE_T state_q, state_d;
    logic [7:0]      srst_cnt_q, srst_cnt_d;
    logic [31:0]     tstamp_q;
    NETTLP_CMD_T     resp_data_q, resp_data_d;

    logic            exec_valid;
    logic            reg_wr_en;
    logic            load_defaults;
    logic [31:0]     reg_rd_data;
    logic [31:0]     rd_data;
    ADAPTER_REGS_T   regs;

    // Register-file side effects are decoded outside the FSM process so the
    // readback path does not loop back through it
    assign exec_valid    = (state_q == EXEC) && fifo_dout.data_valid;
    assign reg_wr_en     = exec_valid && (fifo_dout.cmd.opcode == NETTLP_CMD_REG_WR);
    assign load_defaults = exec_valid && (fifo_dout.cmd.opcode == NETTLP_CMD_RST_ALL);

    nettlp_adapter_regs #(
        .MAGIC_VALUE  (MAGIC_VALUE),
        .REGS_DEFAULT (REGS_DEFAULT)
    ) u_regs (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_defaults_i (load_defaults),
        .wr_en_i         (reg_wr_en),
        .addr_i          (fifo_dout.cmd.dwaddr),
        .wr_data_i       (fifo_dout.cmd.data),
        .rd_data_o       (reg_rd_data),
        .regs_o          (regs)
    );

`ifdef NETTLP_CMD_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        errcnt_sel;
    logic        rd_hit;
    logic        wr_hit;
    logic        err_inc;

    // Error classification, error-counter readback and saturating count update
    always_comb begin
        errcnt_sel = (fifo_dout.cmd.dwaddr == ADAPTER_REG_ERRCNT);
        rd_hit     = adapter_reg_mapped(fifo_dout.cmd.dwaddr) || errcnt_sel;
        wr_hit     = (adapter_reg_mapped(fifo_dout.cmd.dwaddr) &&
                      (fifo_dout.cmd.dwaddr != ADAPTER_REG_MAGIC)) || errcnt_sel;
        rd_data    = reg_rd_data;
        if (errcnt_sel) begin
            rd_data = (fifo_dout.cmd.opcode == NETTLP_CMD_REG_WR) ? 32'h0 : {16'h0, err_cnt_q};
        end
        err_inc = 1'b0;
        case (fifo_dout.cmd.opcode)
            NETTLP_CMD_REG_RD:  err_inc = exec_valid && !rd_hit;
            NETTLP_CMD_REG_WR:  err_inc = exec_valid && !wr_hit;
            NETTLP_CMD_MAGIC,
            NETTLP_CMD_TSTAMP,
            NETTLP_CMD_RST_ALL: err_inc = 1'b0;
            default:            err_inc = exec_valid;
        endcase
        err_cnt_d = err_cnt_q;
        if (load_defaults || (reg_wr_en && errcnt_sel)) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`else
    assign rd_data = reg_rd_data;
`endif

    // Command FSM: next state, FIFO pop and response assembly
    always_comb begin
        state_d     = state_q;
        srst_cnt_d  = srst_cnt_q;
        resp_data_d = resp_data_q;
        fifo_rd_en  = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so no pop is requested while held in reset
                fifo_rd_en = rst_n && !fifo_empty;
                if (!fifo_empty) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!fifo_dout.data_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d            = RESP;
                    resp_data_d.opcode = fifo_dout.cmd.opcode;
                    resp_data_d.dwaddr = fifo_dout.cmd.dwaddr;
                    case (fifo_dout.cmd.opcode)
                        NETTLP_CMD_REG_RD,
                        NETTLP_CMD_REG_WR:  resp_data_d.data = rd_data;
                        NETTLP_CMD_MAGIC:   resp_data_d.data = MAGIC_VALUE;
                        NETTLP_CMD_TSTAMP:  resp_data_d.data = tstamp_q;
                        NETTLP_CMD_RST_ALL: begin
                            resp_data_d.data = '0;
                            srst_cnt_d       = '0;
                            state_d          = SRST;
                        end
                        default:            resp_data_d.data = NETTLP_CMD_RESP_INVALID;
                    endcase
                end
            end
            SRST: begin
                if (srst_cnt_q == SRST_LAST) begin
                    state_d = RESP;
                end else begin
                    srst_cnt_d = srst_cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, soft-reset counter, free-running timestamp and held response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            srst_cnt_q  <= '0;
            tstamp_q    <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            srst_cnt_q  <= srst_cnt_d;
            tstamp_q    <= tstamp_q + 32'd1;
            resp_data_q <= resp_data_d;
        end
    end

    assign resp_valid   = (state_q == RESP);
    assign soft_rst     = (state_q == SRST);
    assign resp_data    = resp_data_q;
    assign dst_mac      = regs.dst_mac;
    assign src_mac      = regs.src_mac;
    assign dst_ip       = regs.dst_ip;
    assign src_ip       = regs.src_ip;
    assign dst_port     = regs.dst_port;
    assign src_port     = regs.src_port;
    assign requester_id = regs.requester_id;

endmodule

// File: tb/tb_nettlp_cmd_proc.sv
// Self-checking bench for nettlp_cmd_proc: directed cases followed by a
// randomized command stream scored against a behavioural register model.
module tb_nettlp_cmd_proc;
    import nettlp_cmd_pkg::*;

    localparam logic [7:0]  OP_RD    = 8'h10;
    localparam logic [7:0]  OP_WR    = 8'h11;
    localparam logic [7:0]  OP_MAGIC = 8'h20;
    localparam logic [7:0]  OP_TS    = 8'h21;
    localparam logic [7:0]  OP_RST   = 8'h22;
    localparam logic [31:0] MAGIC    = 32'h4E54_4C50;
    localparam int          NCYC_SRST = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    FIFO_NETTLP_CMD_T fifo_dout = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    NETTLP_CMD_T      resp_data;
    logic             soft_rst;
    logic [47:0]      dst_mac, src_mac;
    logic [31:0]      dst_ip, src_ip;
    logic [15:0]      dst_port, src_port, requester_id;

    nettlp_cmd_proc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_dout    (fifo_dout),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .soft_rst     (soft_rst),
        .dst_mac      (dst_mac),
        .src_mac      (src_mac),
        .dst_ip       (dst_ip),
        .src_ip       (src_ip),
        .dst_port     (dst_port),
        .src_port     (src_port),
        .requester_id (requester_id)
    );

    always #5 clk = ~clk;

    // Reference time base: cycles elapsed since reset release
    logic [31:0] cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 32'd0;
        else        cyc <= cyc + 32'd1;
    end

    int n_chk = 0;
    int n_bad = 0;
    int txn_cnt = 0;
    logic [31:0] last_data;

    // Behavioural model of the adapter register file
    logic [47:0] m_dmac, m_smac;
    logic [31:0] m_dip, m_sip;
    logic [15:0] m_dport, m_sport, m_rid;
    logic [15:0] m_err;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_dmac = 48'h0; m_smac = 48'h0; m_dip = 32'h0; m_sip = 32'h0;
        m_dport = 16'h3000; m_sport = 16'h3000; m_rid = 16'h0; m_err = 16'h0;
    endtask

    task automatic err_bump();
`ifdef NETTLP_CMD_ERRCNT_EN
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
`endif
    endtask

    task automatic model_read(input logic [7:0] a, output logic [31:0] v, output bit hit);
        hit = 1'b1;
        case (a)
            8'h00: v = MAGIC;
            8'h01: v = m_dmac[31:0];
            8'h02: v = {16'h0, m_dmac[47:32]};
            8'h03: v = m_smac[31:0];
            8'h04: v = {16'h0, m_smac[47:32]};
            8'h05: v = m_dip;
            8'h06: v = m_sip;
            8'h07: v = {16'h0, m_dport};
            8'h08: v = {16'h0, m_sport};
            8'h09: v = {16'h0, m_rid};
`ifdef NETTLP_CMD_ERRCNT_EN
            8'h20: v = {16'h0, m_err};
`endif
            default: begin v = 32'h0; hit = 1'b0; end
        endcase
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        case (a)
            8'h01: m_dmac[31:0]  = d;
            8'h02: m_dmac[47:32] = d[15:0];
            8'h03: m_smac[31:0]  = d;
            8'h04: m_smac[47:32] = d[15:0];
            8'h05: m_dip   = d;
            8'h06: m_sip   = d;
            8'h07: m_dport = d[15:0];
            8'h08: m_sport = d[15:0];
            8'h09: m_rid   = d[15:0];
`ifdef NETTLP_CMD_ERRCNT_EN
            8'h20: m_err   = 16'h0;
`endif
            default: err_bump();
        endcase
    endtask

    task automatic check_regs(input string tag);
        check_eq(tag, {dst_mac, src_mac, dst_ip, src_ip, dst_port, src_port, requester_id},
                      {m_dmac, m_smac, m_dip, m_sip, m_dport, m_sport, m_rid});
    endtask

    // Push one FIFO entry, execute it and check the response (optionally stalling it)
    task automatic do_cmd(input bit valid, input logic [7:0] op, input logic [7:0] addr,
                          input logic [31:0] data, input int stall);
        logic [31:0] exp;
        logic [31:0] ts;
        bit          hit;
        bit          seen;
        NETTLP_CMD_T held;
        int          n;
        txn_cnt++;
        fifo_empty = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            check_eq("pop_wait", 0, 1);
            fifo_empty = 1'b1;
            return;
        end
        @(negedge clk);
        ts = cyc;
        fifo_dout.data_valid = valid;
        fifo_dout.cmd.opcode = op;
        fifo_dout.cmd.dwaddr = addr;
        fifo_dout.cmd.data   = data;
        fifo_empty = 1'b1;
        exp = 32'h0;
        if (valid) begin
            case (op)
                OP_RD:    begin model_read(addr, exp, hit); if (!hit) err_bump(); end
                OP_WR:    begin model_write(addr, data); model_read(addr, exp, hit); end
                OP_MAGIC: exp = MAGIC;
                OP_TS:    exp = ts;
                OP_RST:   begin model_reset(); exp = 32'h0; end
                default:  begin exp = 32'hFFFF_FFFF; err_bump(); end
            endcase
        end
        $display("txn %0d valid=%0b op=%02h addr=%02h data=%08h expect=%08h stall=%0d",
                 txn_cnt, valid, op, addr, data, exp, stall);
        @(negedge clk);
        if (!valid) begin
            check_eq("no_resp", resp_valid, 0);
            return;
        end
        if (op == OP_RST) begin
            n = 0;
            check_eq("srst_no_resp", resp_valid, 0);
            while (soft_rst === 1'b1 && n < 300) begin
                n++;
                @(negedge clk);
            end
            check_eq("srst_len", n, NCYC_SRST);
        end
        check_eq("resp_valid", resp_valid, 1);
        check_eq("resp_data", resp_data, {op, addr, exp});
        check_regs("regs");
        last_data = resp_data.data;
        if (stall > 0) begin
            held = resp_data;
            resp_ready = 1'b0;
            fifo_empty = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                check_eq("stall_valid", resp_valid, 1);
                check_eq("stall_data", resp_data, held);
                check_eq("stall_rd_en", fifo_rd_en, 0);
            end
            resp_ready = 1'b1;
            fifo_empty = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] t1;
        logic [7:0]  op, addr;
        int          r;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_soft_rst", soft_rst, 0);
        check_eq("rst_rd_en", fifo_rd_en, 0);
        check_regs("rst_regs");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_cmd(1, OP_RD, 8'h00, 32'h0, 0);
        do_cmd(1, OP_RD, 8'h07, 32'h0, 0);
        do_cmd(1, OP_WR, 8'h05, 32'hC0A8_0A01, 0);
        do_cmd(1, OP_WR, 8'h02, 32'hABCD_1234, 0);
        do_cmd(1, OP_TS, 8'h00, 32'h0, 0);
        t1 = last_data;
        do_cmd(1, OP_TS, 8'h00, 32'h0, 0);
        check_eq("ts_delta", last_data - t1, 3);
        do_cmd(1, OP_WR, 8'h09, 32'h0000_BEEF, 0);
        do_cmd(1, OP_RST, 8'h3C, 32'h0, 0);
        do_cmd(1, 8'h55, 8'h01, 32'h1234_5678, 0);
        do_cmd(1, OP_RD, 8'h20, 32'h0, 0);
        do_cmd(0, OP_RD, 8'h00, 32'h0, 0);
        do_cmd(1, OP_MAGIC, 8'h11, 32'h0, 10);
        do_cmd(1, OP_WR, 8'h00, 32'hDEAD_BEEF, 0);

        // Randomized stream
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 20);
            addr = 8'($urandom_range(0, 13));
            if (addr == 8'd10)     addr = 8'h20;
            else if (addr > 8'd10) addr = 8'($urandom_range(0, 255));
            if (r < 6)       op = OP_RD;
            else if (r < 12) op = OP_WR;
            else if (r < 14) op = OP_MAGIC;
            else if (r < 16) op = OP_TS;
            else if (r < 17) op = OP_RST;
            else begin
                op = 8'($urandom_range(0, 255));
                if (op inside {OP_RD, OP_WR, OP_MAGIC, OP_TS, OP_RST}) op = 8'h55;
            end
            do_cmd((r != 20), op, addr, $urandom,
                   ($urandom_range(0, 9) < 3) ? $urandom_range(1, 4) : 0);
        end

        // Reset asserted while a response is pending
        fifo_empty = 1'b0;
        resp_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) break;
        end
        @(negedge clk);
        fifo_dout.data_valid = 1'b1;
        fifo_dout.cmd.opcode = OP_WR;
        fifo_dout.cmd.dwaddr = 8'h06;
        fifo_dout.cmd.data   = 32'h0A0B_0C0D;
        fifo_empty = 1'b1;
        @(negedge clk);
        check_eq("pre_rst_valid", resp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_valid", resp_valid, 0);
        check_eq("async_rst_data", resp_data, 0);
        check_regs("async_rst_regs");
        resp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("lost_cmd_no_resp", resp_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
